// File: rtl/bcrypt_cmp.sv
// Hash comparator: byte-loaded 31-bit hash RAM plus a sequential search engine
// that reports the first stored word equal to the sampled hash.
module bcrypt_cmp #(
    parameter int HASH_NUM_MSB   = 9,
    parameter int HASH_COUNT_MSB = HASH_NUM_MSB + 1
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [HASH_NUM_MSB+2:0] cmp_wr_addr,
    input  logic                    cmp_wr_en,
    input  logic [7:0]              cmp_din,
    input  logic [HASH_COUNT_MSB:0] hash_count,
    input  logic                    start,
    input  logic [30:0]             hash_in,
    output logic                    ready,
    output logic                    done,
    output logic                    found,
    output logic [HASH_NUM_MSB:0]   hash_num,
    output logic                    error
);

    localparam int WORDS = 2 ** (HASH_NUM_MSB + 1);
    localparam int IW    = HASH_NUM_MSB + 1;
    localparam int CW    = HASH_NUM_MSB + 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CMP,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [30:0]   ram [WORDS];
    logic [30:0]   ram_q;
    logic [IW-1:0] rd_addr;
    logic [IW-1:0] wr_idx;
    logic [1:0]    wr_lane;
    logic [23:0]   staging;

    logic [30:0]   target;
    logic [CW-1:0] n_q;
    logic [CW-1:0] n_eff;
    logic [CW-1:0] cmp_idx;

    logic          accept;
    logic          abort;
    logic          hit;
    logic          last;

    assign wr_idx  = cmp_wr_addr[HASH_NUM_MSB+2:2];
    assign wr_lane = cmp_wr_addr[1:0];

    // RAM has no reset so stored hashes survive rst
    always_ff @(posedge CLK) begin
        if (cmp_wr_en && (wr_lane == 2'd3)) begin
            ram[wr_idx] <= {cmp_din[6:0], staging};
        end
        ram_q <= ram[rd_addr];
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            staging <= '0;
        end else if (cmp_wr_en) begin
            case (wr_lane)
                2'd0:    staging[7:0]   <= cmp_din;
                2'd1:    staging[15:8]  <= cmp_din;
                2'd2:    staging[23:16] <= cmp_din;
                default: ;
            endcase
        end
    end

    // Clamp the requested count to the RAM depth
    always_comb begin
        n_eff = CW'(hash_count);
        if (32'(hash_count) > 32'(WORDS)) begin
            n_eff = CW'(WORDS);
        end
    end

    assign ready  = (state_q == IDLE) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign accept = ready && start;
    assign abort  = cmp_wr_en && ((state_q == READ) || (state_q == CMP));
    assign hit    = (state_q == CMP) && (ram_q == target);
    assign last   = (cmp_idx + CW'(1)) == n_q;

    // While comparing word i, the read of word i+1 is already in flight
    always_comb begin
        rd_addr = '0;
        if (state_q == CMP) begin
            rd_addr = cmp_idx[IW-1:0] + IW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (abort || (n_q == '0)) begin
                    state_d = DONE;
                end else begin
                    state_d = CMP;
                end
            end
            CMP: begin
                if (abort || hit || last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            found    <= 1'b0;
            hash_num <= '0;
            error    <= 1'b0;
            target   <= '0;
            n_q      <= '0;
            cmp_idx  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                target <= hash_in;
                n_q    <= n_eff;
                found  <= 1'b0;
            end
            if (state_q == READ) begin
                cmp_idx <= '0;
            end else if (state_q == CMP) begin
                cmp_idx <= cmp_idx + CW'(1);
            end
            // A write during the search wins over a simultaneous match
            if (hit && !abort) begin
                found    <= 1'b1;
                hash_num <= cmp_idx[IW-1:0];
            end
            if (abort) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcrypt_cmp.sv
// Directed self-checking bench for bcrypt_cmp: load, match/no-match latency,
// back-to-back starts, write abort, reset abort and count clamping.
module tb_bcrypt_cmp;

    logic        CLK;
    logic        rst;
    logic [11:0] cmp_wr_addr;
    logic        cmp_wr_en;
    logic [7:0]  cmp_din;
    logic [10:0] hash_count;
    logic        start;
    logic [30:0] hash_in;
    logic        ready;
    logic        done;
    logic        found;
    logic [9:0]  hash_num;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    bcrypt_cmp dut (
        .CLK        (CLK),
        .rst        (rst),
        .cmp_wr_addr(cmp_wr_addr),
        .cmp_wr_en  (cmp_wr_en),
        .cmp_din    (cmp_din),
        .hash_count (hash_count),
        .start      (start),
        .hash_in    (hash_in),
        .ready      (ready),
        .done       (done),
        .found      (found),
        .hash_num   (hash_num),
        .error      (error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic write_byte(input logic [9:0] idx, input logic [1:0] lane, input logic [7:0] data);
        cmp_wr_addr = {idx, lane};
        cmp_din     = data;
        cmp_wr_en   = 1'b1;
        @(posedge CLK);
        #1;
        cmp_wr_en = 1'b0;
    endtask

    task automatic write_word(input logic [9:0] idx, input logic [31:0] word);
        write_byte(idx, 2'd0, word[7:0]);
        write_byte(idx, 2'd1, word[15:8]);
        write_byte(idx, 2'd2, word[23:16]);
        write_byte(idx, 2'd3, word[31:24]);
    endtask

    // Leaves the bench in cycle T+1 of the search started at cycle T
    task automatic start_search(input logic [10:0] cnt, input logic [30:0] h);
        hash_count = cnt;
        hash_in    = h;
        start      = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int l);
        l = 1;
        while (done !== 1'b1 && l < limit) begin
            @(posedge CLK);
            #1;
            l++;
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b exp 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b exp 0", done); end
        n_checks++; if (found !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_found: got %b exp 0", found); end
        n_checks++; if (hash_num !== 10'd0) begin n_fail++; $display("[TB] FAIL reset_hash_num: got %0d exp 0", hash_num); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_error: got %b exp 0", error); end
        @(posedge CLK);
        #1;
        rst = 1'b0;
        start_search(11'd0, 31'h0);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL first_start_ready: got %b exp 0", ready); end
        wait_done(10, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL first_start_lat: got %0d exp 2", lat); end
    endtask

    task automatic test_fill;
        write_byte(10'd0, 2'd0, 8'hA5);
        write_byte(10'd0, 2'd1, 8'hA5);
        write_byte(10'd0, 2'd2, 8'hA5);
        for (int i = 0; i < 1024; i++) begin
            write_byte(10'(i), 2'd3, 8'h5A);
        end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_error: got %b exp 0", error); end
        start_search(11'd4, 31'h5AA5A5A5);
        wait_done(20, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL fill_lat: got %0d exp 3", lat); end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_found: got %b exp 1", found); end
    endtask

    task automatic test_match;
        write_word(10'd0, 32'h11111111);
        write_word(10'd1, 32'h22222222);
        write_word(10'd2, 32'h33333333);
        write_word(10'd3, 32'h44444444);
        start_search(11'd4, 31'h33333333);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL match_busy: got %b exp 0", ready); end
        wait_done(20, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("[TB] FAIL match_lat: got %0d exp 5", lat); end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL match_found: got %b exp 1", found); end
        n_checks++; if (hash_num !== 10'd2) begin n_fail++; $display("[TB] FAIL match_hash_num: got %0d exp 2", hash_num); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL match_ready: got %b exp 1", ready); end
        @(posedge CLK);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_pulse: got %b exp 0", done); end
    endtask

    task automatic test_no_match;
        start_search(11'd4, 31'h55555555);
        wait_done(20, lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("[TB] FAIL nomatch_lat: got %0d exp 6", lat); end
        n_checks++; if (found !== 1'b0) begin n_fail++; $display("[TB] FAIL nomatch_found: got %b exp 0", found); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL nomatch_ready: got %b exp 1", ready); end
        n_checks++; if (hash_num !== 10'd2) begin n_fail++; $display("[TB] FAIL nomatch_hash_num: got %0d exp 2", hash_num); end
    endtask

    task automatic test_bit31;
        write_word(10'd0, 32'hFFFFFFFF);
        start_search(11'd1, 31'h7FFFFFFF);
        wait_done(20, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("[TB] FAIL bit31_lat: got %0d exp 3", lat); end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL bit31_found: got %b exp 1", found); end
        n_checks++; if (hash_num !== 10'd0) begin n_fail++; $display("[TB] FAIL bit31_hash_num: got %0d exp 0", hash_num); end
    endtask

    task automatic test_back_to_back;
        start_search(11'd0, 31'h44444444);
        wait_done(20, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL zero_lat: got %0d exp 2", lat); end
        n_checks++; if (found !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_found: got %b exp 0", found); end
        start_search(11'd4, 31'h44444444);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_accept: got %b exp 0", ready); end
        wait_done(20, lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("[TB] FAIL b2b_lat: got %0d exp 6", lat); end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_found: got %b exp 1", found); end
        n_checks++; if (hash_num !== 10'd3) begin n_fail++; $display("[TB] FAIL b2b_hash_num: got %0d exp 3", hash_num); end
    endtask

    task automatic test_write_abort;
        start_search(11'd4, 31'h22222222);
        @(posedge CLK);
        #1;
        cmp_wr_addr = {10'd10, 2'd3};
        cmp_din     = 8'h12;
        cmp_wr_en   = 1'b1;
        @(posedge CLK);
        #1;
        cmp_wr_en = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_done: got %b exp 1", done); end
        n_checks++; if (found !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_found: got %b exp 0", found); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_error: got %b exp 1", error); end
        start_search(11'd16, 31'h12FFFFFF);
        wait_done(40, lat);
        n_checks++; if (lat !== 13) begin n_fail++; $display("[TB] FAIL abortwr_lat: got %0d exp 13", lat); end
        n_checks++; if (hash_num !== 10'd10) begin n_fail++; $display("[TB] FAIL abortwr_hash_num: got %0d exp 10", hash_num); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("[TB] FAIL error_sticky: got %b exp 1", error); end
    endtask

    task automatic test_rst_abort;
        start_search(11'd4, 31'h44444444);
        @(posedge CLK);
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_ready: got %b exp 1", ready); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_error: got %b exp 0", error); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b exp 0", done); end
        @(posedge CLK);
        #1;
        rst = 1'b0;
        start_search(11'd4, 31'h44444444);
        wait_done(20, lat);
        n_checks++; if (lat !== 6) begin n_fail++; $display("[TB] FAIL rerun_lat: got %0d exp 6", lat); end
        n_checks++; if (hash_num !== 10'd3) begin n_fail++; $display("[TB] FAIL rerun_hash_num: got %0d exp 3", hash_num); end
        write_byte(10'd20, 2'd3, 8'h81);
        start_search(11'd21, 31'h01000000);
        wait_done(40, lat);
        n_checks++; if (lat !== 23) begin n_fail++; $display("[TB] FAIL staging_lat: got %0d exp 23", lat); end
        n_checks++; if (hash_num !== 10'd20) begin n_fail++; $display("[TB] FAIL staging_hash_num: got %0d exp 20", hash_num); end
    endtask

    task automatic test_clamp;
        start_search(11'd2047, 31'h7EDCBA98);
        lat = 1;
        while (done !== 1'b1 && lat < 1200) begin
            if (lat == 5) begin
                start      = 1'b1;
                hash_in    = 31'h5AA5A5A5;
                hash_count = 11'd4;
            end else begin
                start = 1'b0;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        start = 1'b0;
        n_checks++; if (lat !== 1026) begin n_fail++; $display("[TB] FAIL clamp_lat: got %0d exp 1026", lat); end
        n_checks++; if (found !== 1'b0) begin n_fail++; $display("[TB] FAIL clamp_found: got %b exp 0", found); end
    endtask

    initial begin
        rst         = 1'b1;
        cmp_wr_addr = '0;
        cmp_wr_en   = 1'b0;
        cmp_din     = '0;
        hash_count  = '0;
        start       = 1'b0;
        hash_in     = '0;
        test_reset();
        test_fill();
        test_match();
        test_no_match();
        test_bit31();
        test_back_to_back();
        test_write_abort();
        test_rst_abort();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
